ex_hazard_ctrl: RTL and testbench
=================================

# ex_hazard_ctrl

Pipeline hazard and sequencing controller for the execute stage. It tracks the destination registers of the instructions in EX, MEM and WB and drives the execute stage's `forward_sel_a` / `forward_sel_b` operand muxes. It detects load-use hazards and inserts a one-cycle stall. When a branch is taken in EX it squashes the younger instructions and raises a redirect, and it holds the architectural NZCV flag register. It sits between the decode/control unit and `execute_stage`, and also drives the IF/ID and ID/EX pipeline-register enables and flushes.

## Interface
- `REG_W`, 4, register index width
- `CNT_W`, 16, width of the stall and flush event counters
- `clk` in 1: rising-edge clock
- `reset` in 1: asynchronous, active-low reset
- `id_valid` in 1: instruction present in ID
- `id_rn`, `id_rm` in REG_W: ID source register indices
- `id_uses_rn`, `id_uses_rm` in 1: ID actually reads the corresponding source
- `id_rd` in REG_W: ID destination register
- `id_writes_rd` in 1: ID writes `id_rd`
- `id_is_load` in 1: ID is a load
- `id_sets_flags` in 1: ID updates NZCV (S bit)
- `id_is_branch` in 1: ID is a branch
- `ex_branch_taken` in 1: `branch_taken` from `execute_stage`
- `ex_flags` in 4: ALU `{N,Z,C,V}` from `execute_stage`
- `forward_sel_a`, `forward_sel_b` out 2: execute-stage operand mux select; 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result
- `stall_if_id` out 1: hold PC and IF/ID
- `flush_id_ex` out 1: load a bubble into ID/EX
- `flush_if_id` out 1: load a bubble into IF/ID
- `branch_redirect` out 1: the PC takes `branch_target` this cycle
- `flags_q` out 4: architectural NZCV
- `stall_count`, `flush_count` out CNT_W: saturating event counters

## Operation
- **Slot records.** Three slot registers, EX, MEM and WB. Each record holds {valid, rd, writes, is_load, sets_flags, is_branch, rn, rm, uses_rn, uses_rm}.
- **Advance.** Every clock, EX→MEM and MEM→WB. The old WB record is dropped. ID enters EX, or a bubble (valid=0) enters EX when `flush_id_ex` is asserted.
- **Forwarding (combinational, from the EX record).** For each source used:
  - MEM.valid & MEM.writes & MEM.rd==src: select 01.
  - Otherwise, the same match on WB: select 10.
  - Otherwise: select 00.
  - MEM has priority over WB.
  - Source index 15 (PC) always selects 00.
  - An unused source selects 00.
- **Load-use hazard.** `load_use` = id_valid & EX.valid & EX.is_load & EX.writes & ((id_uses_rn & id_rn==EX.rd) | (id_uses_rm & id_rm==EX.rd)).
  - Response: `stall_if_id`=1 and `flush_id_ex`=1 for exactly one cycle.
  - Next cycle the load is in MEM and the bubble is in EX; the dependent instruction enters EX one cycle later and forwards from WB (10).
- **Branch.** `take` = EX.valid & EX.is_branch & ex_branch_taken.
  - Response: `branch_redirect`=1, `flush_if_id`=1 and `flush_id_ex`=1 in the same cycle, squashing two younger instructions.
  - `stall_if_id` is forced to 0.
- **Simultaneous load-use and taken branch.** The branch wins: no stall is issued and the stall counter does not increment.
- **Flags.** `flags_q` <= `ex_flags` when EX.valid & EX.sets_flags. A squashed (bubble) slot never updates the flags.
- **Counters.**
  - `stall_count` increments on each cycle of `load_use` & !`take`.
  - `flush_count` increments on each `take`.
  - Both saturate at all-ones, with no wrap.

## Timing
- Forward selects, `stall_if_id`, the flushes and `branch_redirect` are combinational from the slot registers and the current ID/EX inputs; there is no added latency.
- Slot records, `flags_q` and the counters update on the rising edge of `clk`.
- A load-use stall costs one bubble; a taken branch costs two bubbles.
- Back-to-back load-use hazards (a chain of loads) each stall one cycle independently.
- A branch immediately following a stall resolves normally.
- Reset (asynchronous, at any time, including mid-stall):
  - All slots become invalid; `flags_q`=0; counters become 0.
  - Therefore `forward_sel_*`=00 and `stall_if_id`, flushes and `branch_redirect` are 0 for as long as `reset` is low.
  - The first edge after `reset` rises loads ID normally.

## Structure
- Shared header `ex_ctrl_defs.vh` holds:
  - Forward-select constants `FWD_REG`=2'b00, `FWD_EX_MEM`=2'b01, `FWD_MEM_WB`=2'b10.
  - The `PC_IDX`=15 constant.
  - Bit offsets of the slot record fields.
- Sub-module `hazard_slot`: one resettable slot-record register with a bubble-insert input. It is instantiated three times (EX, MEM, WB).
- Forward compare, hazard detect, flag register and counters live in the top level.

## Test plan
- **MEM forward.** `ADD r1` then `SUB r2,r1,r3` back-to-back → when SUB is in EX, `forward_sel_a`=01 and `forward_sel_b`=00.
- **WB forward and priority.**
  - `ADD r1`, NOP, `ORR r4,r1,r1` → both selects are 10.
  - r1 written by both the MEM and WB slots → select 01.
- **Load-use.** `LDR r5` followed by `ADD r6,r5,r0` → one cycle with `stall_if_id`=1 and `flush_id_ex`=1; the ADD then reaches EX with `forward_sel_a`=10; `stall_count`=1.
- **Taken branch during a load-use.** A taken branch in EX while ID presents a load-use pattern → `branch_redirect`, `flush_if_id` and `flush_id_ex` are all 1, `stall_if_id`=0, `flush_count`=1 and `stall_count` is unchanged.
- **Flags.** A flag-setting op with `ex_flags`=4'b0100 → `flags_q`=4'b0100 next cycle. A bubble in EX with arbitrary `ex_flags` → `flags_q` unchanged. Dest r15 → select 00.
- **Reset and saturation.**
  - Assert `reset` low mid-stall → all outputs are 0 immediately (asynchronously) and the counters clear.
  - With CNT_W=2 and 5 stalls → `stall_count`=3.

Source files
------------

// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared types and constants for the execute-stage hazard controller:
// forward-select encodings, the PC register index and the slot record layout.
package ex_hazard_ctrl_pkg;

  localparam int SLOT_REG_W = 4;

  typedef enum logic [1:0] {
    FWD_REG    = 2'b00,
    FWD_EX_MEM = 2'b01,
    FWD_MEM_WB = 2'b10
  } fwd_sel_e;

  localparam logic [SLOT_REG_W-1:0] PC_IDX = 4'd15;

  typedef struct packed {
    logic                  valid;
    logic [SLOT_REG_W-1:0] rd;
    logic                  writes;
    logic                  is_load;
    logic                  sets_flags;
    logic                  is_branch;
    logic [SLOT_REG_W-1:0] rn;
    logic [SLOT_REG_W-1:0] rm;
    logic                  uses_rn;
    logic                  uses_rm;
  } slot_t;

  // The PC is never forwarded; MEM wins over WB when both hold the source.
  function automatic fwd_sel_e fwd_sel(
    input logic                  src_used,
    input logic [SLOT_REG_W-1:0] src,
    input logic                  mem_hit,
    input logic [SLOT_REG_W-1:0] mem_rd,
    input logic                  wb_hit,
    input logic [SLOT_REG_W-1:0] wb_rd
  );
    fwd_sel_e sel;
    sel = FWD_REG;
    if (src_used && src != PC_IDX) begin
      if (mem_hit && mem_rd == src) begin
        sel = FWD_EX_MEM;
      end else if (wb_hit && wb_rd == src) begin
        sel = FWD_MEM_WB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/ex_hazard_ctrl_slot.sv
// One pipeline slot record register; a bubble request loads an invalid record.
module hazard_slot
  import ex_hazard_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  bubble_i,
  input  slot_t d_i,
  output slot_t q_o
);

  slot_t slot_q;
  slot_t slot_d;

  always_comb begin
    slot_d = d_i;
    if (bubble_i) begin
      slot_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign q_o = slot_q;

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller: operand forwarding, load-use stall,
// taken-branch squash, NZCV flag register and saturating event counters.
module ex_hazard_ctrl
  import ex_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = SLOT_REG_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_writes_rd,
  input  logic             id_is_load,
  input  logic             id_sets_flags,
  input  logic             id_is_branch,
  input  logic             ex_branch_taken,
  input  logic [3:0]       ex_flags,
  output logic [1:0]       forward_sel_a,
  output logic [1:0]       forward_sel_b,
  output logic             stall_if_id,
  output logic             flush_id_ex,
  output logic             flush_if_id,
  output logic             branch_redirect,
  output logic [3:0]       flags_q,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  slot_t id_rec;
  slot_t ex_q;
  slot_t mem_q;
  slot_t wb_q;

  logic load_use;
  logic take;
  logic mem_hit;
  logic wb_hit;

  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  always_comb begin
    id_rec            = '0;
    id_rec.valid      = id_valid;
    id_rec.rd         = id_rd;
    id_rec.writes     = id_writes_rd;
    id_rec.is_load    = id_is_load;
    id_rec.sets_flags = id_sets_flags;
    id_rec.is_branch  = id_is_branch;
    id_rec.rn         = id_rn;
    id_rec.rm         = id_rm;
    id_rec.uses_rn    = id_uses_rn;
    id_rec.uses_rm    = id_uses_rm;
  end

  hazard_slot u_ex_slot (
    .clk      (clk),
    .reset    (reset),
    .bubble_i (flush_id_ex),
    .d_i      (id_rec),
    .q_o      (ex_q)
  );

  hazard_slot u_mem_slot (
    .clk      (clk),
    .reset    (reset),
    .bubble_i (1'b0),
    .d_i      (ex_q),
    .q_o      (mem_q)
  );

  hazard_slot u_wb_slot (
    .clk      (clk),
    .reset    (reset),
    .bubble_i (1'b0),
    .d_i      (mem_q),
    .q_o      (wb_q)
  );

  assign mem_hit = mem_q.valid & mem_q.writes;
  assign wb_hit  = wb_q.valid & wb_q.writes;

  assign forward_sel_a = fwd_sel(ex_q.uses_rn, ex_q.rn, mem_hit, mem_q.rd, wb_hit, wb_q.rd);
  assign forward_sel_b = fwd_sel(ex_q.uses_rm, ex_q.rm, mem_hit, mem_q.rd, wb_hit, wb_q.rd);

  assign load_use = id_valid & ex_q.valid & ex_q.is_load & ex_q.writes &
                    ((id_uses_rn & (id_rn == ex_q.rd)) | (id_uses_rm & (id_rm == ex_q.rd)));
  assign take     = ex_q.valid & ex_q.is_branch & ex_branch_taken;

  // A taken branch squashes the dependent instruction, so it overrides the stall.
  assign stall_if_id     = load_use & ~take;
  assign flush_id_ex     = load_use | take;
  assign flush_if_id     = take;
  assign branch_redirect = take;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= '0;
    end else if (ex_q.valid && ex_q.sets_flags) begin
      flags_q <= ex_flags;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (stall_if_id && stall_count_q != '1) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
    if (take && flush_count_q != '1) begin
      flush_count_d = flush_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

  logic unused_wb_fields;
  assign unused_wb_fields = ^{wb_q.is_load, wb_q.sets_flags, wb_q.is_branch,
                              wb_q.rn, wb_q.rm, wb_q.uses_rn, wb_q.uses_rm};

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed, table-driven bench for ex_hazard_ctrl with hand-computed expectations,
// plus sequences for asynchronous reset mid-stall and counter saturation.
module tb_ex_hazard_ctrl;

  typedef struct packed {
    logic       valid;
    logic [3:0] rn;
    logic [3:0] rm;
    logic       usesRn;
    logic       usesRm;
    logic [3:0] rd;
    logic       writes;
    logic       isLoad;
    logic       setsFlags;
    logic       isBranch;
  } instr_t;

  typedef struct {
    string       name;
    instr_t      ins;
    logic        brTaken;
    logic [3:0]  exFlags;
    logic [1:0]  expFwdA;
    logic [1:0]  expFwdB;
    logic [3:0]  expCtrl;
    logic [3:0]  expFlags;
    logic [15:0] expStallCnt;
    logic [15:0] expFlushCnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        idValid;
  logic [3:0]  idRn, idRm, idRd;
  logic        idUsesRn, idUsesRm, idWritesRd, idIsLoad, idSetsFlags, idIsBranch;
  logic        exBranchTaken;
  logic [3:0]  exFlags;

  logic [1:0]  fwdA, fwdB;
  logic        stallIfId, flushIdEx, flushIfId, redirect;
  logic [3:0]  flagsQ;
  logic [15:0] stallCount, flushCount;

  logic [1:0]  satFwdA, satFwdB;
  logic        satStallIfId, satFlushIdEx, satFlushIfId, satRedirect;
  logic [3:0]  satFlagsQ;
  logic [1:0]  satStallCount, satFlushCount;

  int checks = 0;
  int errors = 0;

  vec_t vecs[32];
  int   nVec = 0;

  always #5 clk = ~clk;

  ex_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(idValid), .id_rn(idRn), .id_rm(idRm),
    .id_uses_rn(idUsesRn), .id_uses_rm(idUsesRm), .id_rd(idRd), .id_writes_rd(idWritesRd),
    .id_is_load(idIsLoad), .id_sets_flags(idSetsFlags), .id_is_branch(idIsBranch),
    .ex_branch_taken(exBranchTaken), .ex_flags(exFlags),
    .forward_sel_a(fwdA), .forward_sel_b(fwdB), .stall_if_id(stallIfId),
    .flush_id_ex(flushIdEx), .flush_if_id(flushIfId), .branch_redirect(redirect),
    .flags_q(flagsQ), .stall_count(stallCount), .flush_count(flushCount)
  );

  ex_hazard_ctrl #(.CNT_W(2)) dutSat (
    .clk(clk), .reset(reset), .id_valid(idValid), .id_rn(idRn), .id_rm(idRm),
    .id_uses_rn(idUsesRn), .id_uses_rm(idUsesRm), .id_rd(idRd), .id_writes_rd(idWritesRd),
    .id_is_load(idIsLoad), .id_sets_flags(idSetsFlags), .id_is_branch(idIsBranch),
    .ex_branch_taken(exBranchTaken), .ex_flags(exFlags),
    .forward_sel_a(satFwdA), .forward_sel_b(satFwdB), .stall_if_id(satStallIfId),
    .flush_id_ex(satFlushIdEx), .flush_if_id(satFlushIfId), .branch_redirect(satRedirect),
    .flags_q(satFlagsQ), .stall_count(satStallCount), .flush_count(satFlushCount)
  );

  function automatic instr_t mkNop();
    instr_t r;
    r = '0;
    return r;
  endfunction

  function automatic instr_t mkAlu(input logic [3:0] rd, input logic [3:0] rn,
                                   input logic [3:0] rm, input logic sf);
    instr_t r;
    r = '0;
    r.valid = 1'b1; r.rd = rd; r.writes = 1'b1; r.setsFlags = sf;
    r.rn = rn; r.rm = rm; r.usesRn = 1'b1; r.usesRm = 1'b1;
    return r;
  endfunction

  function automatic instr_t mkLoad(input logic [3:0] rd, input logic [3:0] rn);
    instr_t r;
    r = '0;
    r.valid = 1'b1; r.rd = rd; r.writes = 1'b1; r.isLoad = 1'b1;
    r.rn = rn; r.usesRn = 1'b1;
    return r;
  endfunction

  function automatic instr_t mkBranch(input logic [3:0] rn);
    instr_t r;
    r = '0;
    r.valid = 1'b1; r.isBranch = 1'b1; r.rn = rn; r.usesRn = 1'b1;
    return r;
  endfunction

  task automatic addVec(input string nm, input instr_t ins, input logic bt, input logic [3:0] ef,
                        input logic [1:0] fa, input logic [1:0] fb, input logic [3:0] ctrl,
                        input logic [3:0] fl, input logic [15:0] sc, input logic [15:0] fc);
    vecs[nVec].name        = nm;
    vecs[nVec].ins         = ins;
    vecs[nVec].brTaken     = bt;
    vecs[nVec].exFlags     = ef;
    vecs[nVec].expFwdA     = fa;
    vecs[nVec].expFwdB     = fb;
    vecs[nVec].expCtrl     = ctrl;
    vecs[nVec].expFlags    = fl;
    vecs[nVec].expStallCnt = sc;
    vecs[nVec].expFlushCnt = fc;
    nVec++;
  endtask

  task automatic driveInstr(input instr_t ins);
    idValid     = ins.valid;
    idRn        = ins.rn;
    idRm        = ins.rm;
    idUsesRn    = ins.usesRn;
    idUsesRm    = ins.usesRm;
    idRd        = ins.rd;
    idWritesRd  = ins.writes;
    idIsLoad    = ins.isLoad;
    idSetsFlags = ins.setsFlags;
    idIsBranch  = ins.isBranch;
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 2 units later.
  task automatic applyStimulus(input instr_t ins, input logic bt, input logic [3:0] ef);
    @(posedge clk);
    #1;
    driveInstr(ins);
    exBranchTaken = bt;
    exFlags       = ef;
  endtask

  task automatic checkOutput(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic checkVector(input vec_t v);
    #2;
    checkOutput({v.name, " fwdA"}, 16'(fwdA), 16'(v.expFwdA));
    checkOutput({v.name, " fwdB"}, 16'(fwdB), 16'(v.expFwdB));
    checkOutput({v.name, " ctrl"}, 16'({stallIfId, flushIdEx, flushIfId, redirect}), 16'(v.expCtrl));
    checkOutput({v.name, " flags"}, 16'(flagsQ), 16'(v.expFlags));
    checkOutput({v.name, " stallCnt"}, stallCount, v.expStallCnt);
    checkOutput({v.name, " flushCnt"}, flushCount, v.expFlushCnt);
  endtask

  initial begin
    instr_t ldrPc;
    ldrPc = mkLoad(4'd15, 4'd1);
    ldrPc.isBranch = 1'b1;

    // ctrl = {stall_if_id, flush_id_ex, flush_if_id, branch_redirect}
    addVec("v00 add r1",       mkAlu(4'd1, 4'd2, 4'd3, 1'b0),  1'b0, 4'h0, 2'b00, 2'b00, 4'b0000, 4'h0, 16'd0, 16'd0);
    addVec("v01 sub r2,r1",    mkAlu(4'd2, 4'd1, 4'd3, 1'b0),  1'b0, 4'h0, 2'b00, 2'b00, 4'b0000, 4'h0, 16'd0, 16'd0);
    addVec("v02 mem fwd",      mkNop(),                        1'b0, 4'h0, 2'b01, 2'b00, 4'b0000, 4'h0, 16'd0, 16'd0);
    addVec("v03 orr r4,r2,r2", mkAlu(4'd4, 4'd2, 4'd2, 1'b0),  1'b0, 4'h0, 2'b00, 2'b00, 4'b0000, 4'h0, 16'd0, 16'd0);
    addVec("v04 wb fwd",       mkAlu(4'd7, 4'd0, 4'd0, 1'b0),  1'b0, 4'h0, 2'b10, 2'b10, 4'b0000, 4'h0, 16'd0, 16'd0);
    addVec("v05 adds r7",      mkAlu(4'd7, 4'd0, 4'd0, 1'b1),  1'b0, 4'h0, 2'b00, 2'b00, 4'b0000, 4'h0, 16'd0, 16'd0);
    addVec("v06 and r8,r7,pc", mkAlu(4'd8, 4'd7, 4'd15, 1'b0), 1'b0, 4'h4, 2'b00, 2'b00, 4'b0000, 4'h0, 16'd0, 16'd0);
    addVec("v07 prio pc flag", mkNop(),                        1'b0, 4'hF, 2'b01, 2'b00, 4'b0000, 4'h4, 16'd0, 16'd0);
    addVec("v08 bubble flags", mkNop(),                        1'b0, 4'hA, 2'b00, 2'b00, 4'b0000, 4'h4, 16'd0, 16'd0);
    addVec("v09 ldr r5",       mkLoad(4'd5, 4'd2),             1'b0, 4'h0, 2'b00, 2'b00, 4'b0000, 4'h4, 16'd0, 16'd0);
    addVec("v10 load-use",     mkAlu(4'd6, 4'd5, 4'd0, 1'b0),  1'b0, 4'h0, 2'b00, 2'b00, 4'b1100, 4'h4, 16'd0, 16'd0);
    addVec("v11 held add",     mkAlu(4'd6, 4'd5, 4'd0, 1'b0),  1'b0, 4'h0, 2'b00, 2'b00, 4'b0000, 4'h4, 16'd1, 16'd0);
    addVec("v12 add wb fwd",   mkNop(),                        1'b1, 4'hF, 2'b10, 2'b00, 4'b0000, 4'h4, 16'd1, 16'd0);
    addVec("v13 ldr pc",       ldrPc,                          1'b0, 4'h0, 2'b00, 2'b00, 4'b0000, 4'h4, 16'd1, 16'd0);
    addVec("v14 br+loaduse",   mkAlu(4'd10, 4'd15, 4'd0, 1'b0),1'b1, 4'h0, 2'b00, 2'b00, 4'b0111, 4'h4, 16'd1, 16'd0);
    addVec("v15 after take",   mkNop(),                        1'b0, 4'h0, 2'b00, 2'b00, 4'b0000, 4'h4, 16'd1, 16'd1);
    addVec("v16 ldr r3",       mkLoad(4'd3, 4'd1),             1'b0, 4'h0, 2'b00, 2'b00, 4'b0000, 4'h4, 16'd1, 16'd1);
    addVec("v17 bx r3 stall",  mkBranch(4'd3),                 1'b0, 4'h0, 2'b00, 2'b00, 4'b1100, 4'h4, 16'd1, 16'd1);
    addVec("v18 bx r3 held",   mkBranch(4'd3),                 1'b0, 4'h0, 2'b00, 2'b00, 4'b0000, 4'h4, 16'd2, 16'd1);
    addVec("v19 bx taken",     mkNop(),                        1'b1, 4'h0, 2'b10, 2'b00, 4'b0111, 4'h4, 16'd2, 16'd1);
    addVec("v20 after bx",     mkNop(),                        1'b0, 4'h0, 2'b00, 2'b00, 4'b0000, 4'h4, 16'd2, 16'd2);
    addVec("v21 ldr r1",       mkLoad(4'd1, 4'd2),             1'b0, 4'h0, 2'b00, 2'b00, 4'b0000, 4'h4, 16'd2, 16'd2);
    addVec("v22 ldr chain 1",  mkLoad(4'd2, 4'd1),             1'b0, 4'h0, 2'b00, 2'b00, 4'b1100, 4'h4, 16'd2, 16'd2);
    addVec("v23 ldr held",     mkLoad(4'd2, 4'd1),             1'b0, 4'h0, 2'b00, 2'b00, 4'b0000, 4'h4, 16'd3, 16'd2);
    addVec("v24 ldr chain 2",  mkAlu(4'd3, 4'd2, 4'd0, 1'b0),  1'b0, 4'h0, 2'b10, 2'b00, 4'b1100, 4'h4, 16'd3, 16'd2);
    addVec("v25 add held",     mkAlu(4'd3, 4'd2, 4'd0, 1'b0),  1'b0, 4'h0, 2'b00, 2'b00, 4'b0000, 4'h4, 16'd4, 16'd2);
    addVec("v26 add wb fwd",   mkNop(),                        1'b0, 4'h0, 2'b10, 2'b00, 4'b0000, 4'h4, 16'd4, 16'd2);

    reset = 1'b0;
    driveInstr(mkNop());
    exBranchTaken = 1'b0;
    exFlags       = 4'h0;
    #12;
    checkOutput("reset fwdA", 16'(fwdA), 16'd0);
    checkOutput("reset ctrl", 16'({stallIfId, flushIdEx, flushIfId, redirect}), 16'd0);
    checkOutput("reset flags", 16'(flagsQ), 16'd0);
    checkOutput("reset stallCnt", stallCount, 16'd0);
    reset = 1'b1;

    for (int i = 0; i < nVec; i++) begin
      applyStimulus(vecs[i].ins, vecs[i].brTaken, vecs[i].exFlags);
      checkVector(vecs[i]);
    end

    // Asynchronous reset in the middle of a load-use stall.
    applyStimulus(mkLoad(4'd5, 4'd2), 1'b0, 4'h0);
    applyStimulus(mkAlu(4'd6, 4'd5, 4'd0, 1'b0), 1'b0, 4'h0);
    #2;
    checkOutput("pre-reset stall", 16'(stallIfId), 16'd1);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("async reset fwdA", 16'(fwdA), 16'd0);
    checkOutput("async reset fwdB", 16'(fwdB), 16'd0);
    checkOutput("async reset ctrl", 16'({stallIfId, flushIdEx, flushIfId, redirect}), 16'd0);
    checkOutput("async reset flags", 16'(flagsQ), 16'd0);
    checkOutput("async reset stallCnt", stallCount, 16'd0);
    checkOutput("async reset flushCnt", flushCount, 16'd0);
    @(posedge clk);
    #3;
    checkOutput("held reset ctrl", 16'({stallIfId, flushIdEx, flushIfId, redirect}), 16'd0);
    driveInstr(mkAlu(4'd1, 4'd2, 4'd3, 1'b0));
    #1;
    reset = 1'b1;
    applyStimulus(mkAlu(4'd2, 4'd1, 4'd3, 1'b0), 1'b0, 4'h0);
    applyStimulus(mkNop(), 1'b0, 4'h0);
    #2;
    checkOutput("post-reset fwdA", 16'(fwdA), 16'd1);
    checkOutput("post-reset fwdB", 16'(fwdB), 16'd0);

    // Five load-use stalls: the 2-bit counter must stick at 3.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(mkLoad(4'd5, 4'd2), 1'b0, 4'h0);
      applyStimulus(mkAlu(4'd6, 4'd5, 4'd0, 1'b0), 1'b0, 4'h0);
      #2;
      checkOutput($sformatf("sat stall %0d", k), 16'(stallIfId), 16'd1);
      applyStimulus(mkAlu(4'd6, 4'd5, 4'd0, 1'b0), 1'b0, 4'h0);
    end
    applyStimulus(mkNop(), 1'b0, 4'h0);
    #2;
    checkOutput("wide stallCnt", stallCount, 16'd5);
    checkOutput("wide flushCnt", flushCount, 16'd0);
    checkOutput("sat stallCnt", 16'(satStallCount), 16'd3);
    checkOutput("sat flushCnt", 16'(satFlushCount), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
